// File: rtl/buck_phase_ctrl.sv
// Buck converter phase controller: P-on until overcurrent, dead time, N-on until zero crossing.
// Break-before-make via ack handshakes, min/max on-time, ack timeouts and latched faults.
module buck_phase_ctrl #(
    parameter int CNT_W  = 8,
    parameter int DT_CYC = 2,
    parameter int MIN_ON = 4,
    parameter int MAX_ON = 64,
    parameter int ACK_TO = 16
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       uv,
    input  logic       oc,
    input  logic       zc,
    input  logic       gp_ack,
    input  logic       gn_ack,
    input  logic       fault_clr,
    output logic       gp,
    output logic       gn,
    output logic       busy,
    output logic       maxon,
    output logic       fault,
    output logic [1:0] fault_code
);

    typedef enum logic [3:0] {
        IDLE, P_REQ, P_ON, P_OFF, DEAD, N_REQ, N_ON, N_OFF, FAULT
    } state_t;

    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_ON - 1);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_ON - 1);
    localparam logic [CNT_W-1:0] ACK_C = CNT_W'(ACK_TO - 1);
    localparam logic [CNT_W-1:0] DT_C  = CNT_W'(DT_CYC - 1);
    localparam logic [CNT_W-1:0] SAT_C = '1;

    logic [1:0] uv_q, oc_q, zc_q, gpa_q, gna_q;
    logic       uv_s, oc_s, zc_s, gpa_s, gna_s;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            uv_q  <= '0;
            oc_q  <= '0;
            zc_q  <= '0;
            gpa_q <= '0;
            gna_q <= '0;
        end else begin
            uv_q  <= {uv_q[0], uv};
            oc_q  <= {oc_q[0], oc};
            zc_q  <= {zc_q[0], zc};
            gpa_q <= {gpa_q[0], gp_ack};
            gna_q <= {gna_q[0], gn_ack};
        end
    end

    assign uv_s  = uv_q[1];
    assign oc_s  = oc_q[1];
    assign zc_s  = zc_q[1];
    assign gpa_s = gpa_q[1];
    assign gna_s = gna_q[1];

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       code_q, code_d;
    logic             maxon_q, maxon_d;
    logic             gp_q, gn_q, busy_q, fault_q;
    logic             ack_to;

    assign ack_to = (cnt_q == ACK_C);

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        maxon_d = 1'b0;
        // Global checks outrank every normal transition; 10 beats 11 beats 01.
        if (state_q != FAULT && gpa_s && gna_s) begin
            state_d = FAULT;
            code_d  = 2'b10;
        end else if ((state_q == N_REQ || state_q == N_ON) && oc_s) begin
            state_d = FAULT;
            code_d  = 2'b11;
        end else begin
            unique case (state_q)
                IDLE: if (uv_s && !gpa_s && !gna_s) state_d = P_REQ;
                P_REQ: begin
                    if (gpa_s) state_d = P_ON;
                    else if (ack_to) begin
                        state_d = FAULT;
                        code_d  = 2'b01;
                    end
                end
                P_ON: begin
                    if (cnt_q >= MIN_C && oc_s) state_d = P_OFF;
                    else if (cnt_q == MAX_C) begin
                        state_d = P_OFF;
                        maxon_d = 1'b1;
                    end
                end
                P_OFF: begin
                    if (!gpa_s) state_d = DEAD;
                    else if (ack_to) begin
                        state_d = FAULT;
                        code_d  = 2'b01;
                    end
                end
                DEAD: if (cnt_q == DT_C) state_d = N_REQ;
                N_REQ: begin
                    if (gna_s) state_d = N_ON;
                    else if (ack_to) begin
                        state_d = FAULT;
                        code_d  = 2'b01;
                    end
                end
                N_ON: if (cnt_q >= MIN_C && zc_s) state_d = N_OFF;
                N_OFF: begin
                    if (!gna_s) state_d = IDLE;
                    else if (ack_to) begin
                        state_d = FAULT;
                        code_d  = 2'b01;
                    end
                end
                FAULT: begin
                    if (fault_clr && !gpa_s && !gna_s) begin
                        state_d = IDLE;
                        code_d  = 2'b00;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Outputs are decoded from the state being entered so they stay registered.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            code_q  <= 2'b00;
            maxon_q <= 1'b0;
            gp_q    <= 1'b0;
            gn_q    <= 1'b0;
            busy_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) cnt_q <= '0;
            else if (cnt_q != SAT_C) cnt_q <= cnt_q + CNT_W'(1);
            code_q  <= code_d;
            maxon_q <= maxon_d;
            gp_q    <= (state_d == P_REQ) || (state_d == P_ON);
            gn_q    <= (state_d == N_REQ) || (state_d == N_ON);
            busy_q  <= (state_d != IDLE) && (state_d != FAULT);
            fault_q <= (state_d == FAULT);
        end
    end

    assign gp         = gp_q;
    assign gn         = gn_q;
    assign busy       = busy_q;
    assign maxon      = maxon_q;
    assign fault      = fault_q;
    assign fault_code = code_q;

endmodule

// File: tb/tb_buck_phase_ctrl.sv
// Directed bench for buck_phase_ctrl with an auto-ack switch model.
// Phase lengths are counted in falling-edge samples of gp/gn/busy.
module tb_buck_phase_ctrl;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       uv = 1'b0, oc = 1'b0, zc = 1'b0;
    logic       fault_clr = 1'b0;
    logic       gp_ack, gn_ack;
    logic       gp, gn, busy, maxon, fault;
    logic [1:0] fault_code;

    logic auto_p = 1'b1, auto_n = 1'b1;
    logic force_p = 1'b0, force_n = 1'b0;
    logic ack_p_auto = 1'b0, ack_n_auto = 1'b0;
    int   n_cmp = 0, n_err = 0;
    int   maxon_cnt = 0, overlap_cnt = 0;

    buck_phase_ctrl dut (
        .clk(clk), .nrst(nrst), .uv(uv), .oc(oc), .zc(zc),
        .gp_ack(gp_ack), .gn_ack(gn_ack), .fault_clr(fault_clr),
        .gp(gp), .gn(gn), .busy(busy), .maxon(maxon),
        .fault(fault), .fault_code(fault_code)
    );

    always #5 clk = ~clk;

    // Switch model: ack mirrors the request shortly after each rising edge.
    always @(posedge clk) begin
        #2;
        ack_p_auto = gp;
        ack_n_auto = gn;
    end
    assign gp_ack = auto_p ? ack_p_auto : force_p;
    assign gn_ack = auto_n ? ack_n_auto : force_n;

    always @(negedge clk) begin
        if (maxon) maxon_cnt++;
        if (gp && gn) overlap_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic run_cycle(input int oc_at, input int zc_at, input bit drop_uv,
                             output int gp_len, output int gap_len,
                             output int gn_len, output int tail_len);
        int n;
        int idx;
        gp_len = 0; gap_len = 0; gn_len = 0; tail_len = 0;
        if (oc_at == -1) oc = 1'b1;
        n = 0;
        while (!gp && n < 100) begin @(negedge clk); n++; end
        if (!gp) begin
            n_cmp++; n_err++;
            $display("FAIL cycle_gp_rise: gp=%0b required 1 within 100 cycles", gp);
            oc = 1'b0;
            return;
        end
        idx = 0;
        while (gp && idx < 200) begin
            gp_len++;
            if (idx == 0 && drop_uv) uv = 1'b0;
            if (idx == oc_at) oc = 1'b1;
            @(negedge clk); idx++;
        end
        oc = 1'b0;
        n = 0;
        while (!gp && !gn && n < 100) begin gap_len++; @(negedge clk); n++; end
        idx = 0;
        while (gn && idx < 200) begin
            gn_len++;
            if (idx == zc_at) zc = 1'b1;
            @(negedge clk); idx++;
        end
        zc = 1'b0;
        n = 0;
        while (busy && n < 100) begin tail_len++; @(negedge clk); n++; end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({gp, gn, busy, maxon, fault, fault_code} !== 7'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b required 0000000",
                     {gp, gn, busy, maxon, fault, fault_code});
        end
        nrst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({gp, gn, busy, fault} !== 4'b0) begin
            n_err++;
            $display("FAIL reset_release_idle: got %b required 0000", {gp, gn, busy, fault});
        end
    endtask

    task automatic test_nominal;
        int gl, dl, nl, tl, m0;
        m0 = maxon_cnt;
        uv = 1'b1;
        run_cycle(10, 8, 1'b1, gl, dl, nl, tl);
        n_cmp++;
        if (gl !== 13) begin n_err++; $display("FAIL nom_gp_len: got %0d required 13", gl); end
        n_cmp++;
        if (dl !== 5) begin n_err++; $display("FAIL nom_gap_len: got %0d required 5", dl); end
        n_cmp++;
        if (nl !== 11) begin n_err++; $display("FAIL nom_gn_len: got %0d required 11", nl); end
        n_cmp++;
        if (tl !== 3) begin n_err++; $display("FAIL nom_tail_len: got %0d required 3", tl); end
        n_cmp++;
        if (maxon_cnt - m0 !== 0) begin
            n_err++;
            $display("FAIL nom_no_maxon: got %0d pulses required 0", maxon_cnt - m0);
        end
    endtask

    task automatic test_maxon;
        int gl, dl, nl, tl, m0;
        m0 = maxon_cnt;
        uv = 1'b1;
        run_cycle(-2, 6, 1'b1, gl, dl, nl, tl);
        n_cmp++;
        if (gl !== 67) begin n_err++; $display("FAIL max_gp_len: got %0d required 67", gl); end
        n_cmp++;
        if (maxon_cnt - m0 !== 1) begin
            n_err++;
            $display("FAIL max_pulse: got %0d pulse cycles required 1", maxon_cnt - m0);
        end
        n_cmp++;
        if (nl !== 9) begin n_err++; $display("FAIL max_gn_len: got %0d required 9", nl); end
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL max_idle: busy=%0b required 0", busy); end
    endtask

    task automatic test_minon;
        int gl, dl, nl, tl, m0;
        m0 = maxon_cnt;
        uv = 1'b1;
        run_cycle(-1, 4, 1'b1, gl, dl, nl, tl);
        n_cmp++;
        if (gl !== 7) begin n_err++; $display("FAIL min_gp_len: got %0d required 7", gl); end
        n_cmp++;
        if (nl !== 7) begin n_err++; $display("FAIL min_gn_len: got %0d required 7", nl); end
        n_cmp++;
        if (dl !== 5) begin n_err++; $display("FAIL min_gap_len: got %0d required 5", dl); end
        n_cmp++;
        if (maxon_cnt - m0 !== 0) begin
            n_err++;
            $display("FAIL min_no_maxon: got %0d pulses required 0", maxon_cnt - m0);
        end
    endtask

    task automatic test_back_to_back;
        int gl, dl, nl, tl, n;
        uv = 1'b1;
        run_cycle(5, 5, 1'b0, gl, dl, nl, tl);
        n_cmp++;
        if (gl !== 8 || nl !== 8) begin
            n_err++;
            $display("FAIL b2b_first_len: got gp %0d gn %0d required 8 8", gl, nl);
        end
        n = 0;
        while (!gp && n < 20) begin n++; @(negedge clk); end
        n_cmp++;
        if (n !== 1) begin n_err++; $display("FAIL b2b_idle_len: got %0d required 1", n); end
        run_cycle(4, 4, 1'b1, gl, dl, nl, tl);
        n_cmp++;
        if (gl !== 7 || nl !== 7 || tl !== 3) begin
            n_err++;
            $display("FAIL b2b_second: got %0d %0d %0d required 7 7 3", gl, nl, tl);
        end
    endtask

    task automatic test_reset_mid;
        int n;
        uv = 1'b1;
        n = 0;
        while (!gp && n < 50) begin @(negedge clk); n++; end
        repeat (5) @(negedge clk);
        uv = 1'b0;
        #2 nrst = 1'b0;
        #1;
        n_cmp++;
        if (gp !== 1'b0) begin n_err++; $display("FAIL rst_async_gp: got %0b required 0", gp); end
        n_cmp++;
        if ({gn, busy, maxon, fault, fault_code} !== 6'b0) begin
            n_err++;
            $display("FAIL rst_async_outs: got %b required 000000",
                     {gn, busy, maxon, fault, fault_code});
        end
        @(negedge clk);
        nrst = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++;
        if ({gp, gn, busy, fault} !== 4'b0) begin
            n_err++;
            $display("FAIL rst_mid_release: got %b required 0000", {gp, gn, busy, fault});
        end
    endtask

    task automatic test_ack_timeout;
        int n;
        auto_p = 1'b0; force_p = 1'b0;
        uv = 1'b1;
        n = 0;
        while (!gp && n < 50) begin @(negedge clk); n++; end
        uv = 1'b0;
        n = 0;
        while (gp && n < 100) begin @(negedge clk); n++; end
        n_cmp++;
        if (n !== 16) begin n_err++; $display("FAIL to_preq_len: got %0d required 16", n); end
        n_cmp++;
        if ({fault, fault_code, gp, busy} !== 5'b10100) begin
            n_err++;
            $display("FAIL to_fault: got %b required 10100", {fault, fault_code, gp, busy});
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (fault !== 1'b1) begin n_err++; $display("FAIL to_latched: got %0b required 1", fault); end
        auto_p = 1'b1;
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        n_cmp++;
        if ({fault, fault_code} !== 3'b000) begin
            n_err++;
            $display("FAIL to_clear: got %b required 000", {fault, fault_code});
        end
    endtask

    task automatic test_overlap;
        int n;
        uv = 1'b1;
        n = 0;
        while (!gn && n < 200) begin @(negedge clk); n++; end
        uv = 1'b0;
        repeat (5) @(negedge clk);
        auto_p = 1'b0; auto_n = 1'b0;
        force_p = 1'b1; force_n = 1'b1;
        n = 0;
        while (gn && n < 20) begin @(negedge clk); n++; end
        n_cmp++;
        if (n !== 3) begin n_err++; $display("FAIL ovl_gn_drop: got %0d cycles required 3", n); end
        n_cmp++;
        if ({fault, fault_code, gp} !== 4'b1100) begin
            n_err++;
            $display("FAIL ovl_fault: got %b required 1100", {fault, fault_code, gp});
        end
        fault_clr = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (fault !== 1'b1) begin n_err++; $display("FAIL ovl_hold: got %0b required 1", fault); end
        force_p = 1'b0; force_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (fault !== 1'b1) begin n_err++; $display("FAIL ovl_sync: got %0b required 1", fault); end
        @(negedge clk);
        n_cmp++;
        if ({fault, fault_code} !== 3'b000) begin
            n_err++;
            $display("FAIL ovl_clear: got %b required 000", {fault, fault_code});
        end
        fault_clr = 1'b0;
        auto_p = 1'b1; auto_n = 1'b1;
    endtask

    task automatic test_oc_n;
        int n;
        uv = 1'b1;
        n = 0;
        while (!gn && n < 200) begin @(negedge clk); n++; end
        uv = 1'b0;
        @(negedge clk);
        oc = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({fault, fault_code, gn} !== 4'b1110) begin
            n_err++;
            $display("FAIL ocn_fault: got %b required 1110", {fault, fault_code, gn});
        end
        oc = 1'b0;
        fault_clr = 1'b1;
        repeat (6) @(negedge clk);
        fault_clr = 1'b0;
        n_cmp++;
        if ({fault, fault_code, busy} !== 4'b0000) begin
            n_err++;
            $display("FAIL ocn_clear: got %b required 0000", {fault, fault_code, busy});
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_maxon();
        test_minon();
        test_back_to_back();
        test_reset_mid();
        test_ack_timeout();
        test_overlap();
        test_oc_n();
        n_cmp++;
        if (overlap_cnt !== 0) begin
            n_err++;
            $display("FAIL gp_gn_overlap: got %0d cycles required 0", overlap_cnt);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
